// File: rtl/aes_sbox_engine.sv
// Time-multiplexed AES SubBytes engine: a LANES-byte word is substituted
// NSBOX bytes per cycle through NSBOX shared S-box lanes, forward or inverse.

// One S-box lane: forward and inverse S-box, built from the GF(2^8) inverse
// and the affine transforms rather than stored as 256-entry tables.
module aes_sbox_lane (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01;
    p = gmul(x, x);
    for (int i = 1; i < 8; i++) begin
      r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] y);
    return rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05;
  endfunction

  // Select forward or inverse substitution
  always_comb begin
    if (inv) dout = ginv(aff_inv(din));
    else     dout = aff_fwd(ginv(din));
  end

endmodule

module aes_sbox_engine #(
  parameter int LANES = 16,
  parameter int NSBOX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);

  localparam int BEATS = LANES / NSBOX;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if (NSBOX < 1 || NSBOX > LANES || (LANES % NSBOX) != 0) begin : g_bad_cfg
      $error("aes_sbox_engine: LANES must be a multiple of NSBOX, 1 <= NSBOX <= LANES");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, nxt;
  logic [LANES-1:0][7:0]   work;
  logic                    mode;
  logic [BW-1:0]           beat;
  logic [NSBOX-1:0][7:0]   sb_in, sb_out;
  logic                    acc, last;

  assign acc      = in_valid & in_ready;
  assign last     = (beat == BW'(BEATS - 1));
  assign out_data = work;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next state; DONE with out_ready and in_valid re-enters RUN directly
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    if (out_ready) nxt = in_valid ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Handshake outputs; in_ready follows out_ready combinationally in DONE
  always_comb begin
    in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    out_valid = (state == DONE);
    busy      = (state == RUN) | (state == DONE);
  end

  // Route the current beat's lane group to the shared S-box lanes
  always_comb begin
    sb_in = '0;
    for (int b = 0; b < BEATS; b++)
      if (beat == BW'(b))
        for (int i = 0; i < NSBOX; i++)
          sb_in[i] = work[b*NSBOX + i];
  end

  generate
    for (genvar g = 0; g < NSBOX; g++) begin : g_lane
      aes_sbox_lane u_lane (.din(sb_in[g]), .inv(mode), .dout(sb_out[g]));
    end
  endgenerate

  // Working register: load on acceptance, substitute one lane group per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      mode <= 1'b0;
      beat <= '0;
    end else if (acc) begin
      work <= in_data;
      mode <= in_inv;
      beat <= '0;
    end else if (state == RUN) begin
      for (int b = 0; b < BEATS; b++)
        if (beat == BW'(b))
          for (int i = 0; i < NSBOX; i++)
            work[b*NSBOX + i] <= sb_out[i];
      beat <= last ? '0 : beat + 1'b1;
    end
  end

endmodule
